// File: rtl/dma_sound_pkg.sv
// Shared definitions for the DMA sound playback path:
// rate codes, sndmode bit positions, bytesel states and sample conversion.
package dma_sound_pkg;

  localparam logic [1:0] RATE_6K25 = 2'b00;
  localparam logic [1:0] RATE_12K5 = 2'b01;
  localparam logic [1:0] RATE_25K  = 2'b10;
  localparam logic [1:0] RATE_50K  = 2'b11;

  localparam int SM_MONO = 2;
  localparam int SM_16B  = 3;

  typedef enum logic {
    BS_HI = 1'b0,
    BS_LO = 1'b1
  } bytesel_e;

  // Signed sample to offset binary, truncated to out_w bits and
  // returned right-aligned.
  function automatic logic [15:0] to_offset(
    input logic [15:0] s,
    input int          out_w
  );
    logic [15:0] u;
    u = s ^ 16'h8000;
    return u >> (16 - out_w);
  endfunction

endpackage

// File: rtl/dma_sound_fifo.sv
// Word FIFO for sound DMA data with two read ports (head, head+1).
// Ports: push/wdata in, pop count 0..2, flush, rd0/rd1 and level out.
module sound_fifo
  import dma_sound_pkg::*;
#(
  parameter int FIFO_AW = 3
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  input  logic               i_push,
  input  logic [15:0]        i_wdata,
  input  logic [1:0]         i_pop,
  output logic [15:0]        o_rd0,
  output logic [15:0]        o_rd1,
  output logic [FIFO_AW:0]   o_level
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [15:0]        r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wp;
  logic [FIFO_AW-1:0] r_rp;
  logic [FIFO_AW:0]   r_level;
  logic [FIFO_AW-1:0] w_rp1;

  assign w_rp1   = r_rp + 1'b1;
  assign o_rd0   = r_mem[r_rp];
  assign o_rd1   = r_mem[w_rp1];
  assign o_level = r_level;

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wp] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (i_push) begin
        r_wp <= r_wp + 1'b1;
      end
      r_rp    <= r_rp + FIFO_AW'(i_pop);
      r_level <= r_level
               + (FIFO_AW+1)'(i_push)
               - (FIFO_AW+1)'(i_pop);
    end
  end

endmodule

// File: rtl/dma_sound_engine.sv
// DMA sound engine: FIFO-buffered playback in 8-bit stereo/mono or
// 16-bit stereo. Ports: clk32/resb, enable, sndmode, SLOAD_N/MDIN in;
// SREQ, audio_left/right, fifo_level, underrun, overflow out.
module dma_sound_engine
  import dma_sound_pkg::*;
#(
  parameter int FIFO_AW    = 3,
  parameter int DIV_BASE   = 640,
  parameter int OUT_W      = 8,
  parameter int REQ_MARGIN = 1
) (
  input  logic               clk32,
  input  logic               resb,
  input  logic               enable,
  input  logic [3:0]         sndmode,
  input  logic               SLOAD_N,
  input  logic [15:0]        MDIN,
  output logic               SREQ,
  output logic [OUT_W-1:0]   audio_left,
  output logic [OUT_W-1:0]   audio_right,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               underrun,
  output logic               overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CNT_W =
    (DIV_BASE > 1) ? $clog2(DIV_BASE) : 1;

  localparam logic [OUT_W-1:0] MID =
    OUT_W'(1) << (OUT_W - 1);
  localparam logic [FIFO_AW:0] LVL_FULL = DEPTH;
  localparam logic [FIFO_AW:0] LVL_TWO  = 2;
  localparam logic [FIFO_AW:0] LVL_REQ  =
    DEPTH - 1 - REQ_MARGIN;
  localparam logic [CNT_W-1:0] CNT_TOP  =
    CNT_W'(DIV_BASE - 1);

  logic [CNT_W-1:0] r_base_cnt;
  logic             r_base_en;
  logic [2:0]       r_aclk_cnt;
  logic             r_sload_d;
  logic [3:0]       r_mode_d;
  bytesel_e         r_bytesel;
  logic [OUT_W-1:0] r_left;
  logic [OUT_W-1:0] r_right;
  logic             r_under;
  logic             r_over;
  logic             r_sreq;

  logic             w_rate_ok;
  logic             w_tick;
  logic             w_push_req;
  logic             w_full;
  logic             w_push;
  logic             w_16b;
  logic             w_mono;
  logic             w_mode_chg;
  logic [15:0]      w_rd0;
  logic [15:0]      w_rd1;
  logic [7:0]       w_mono_b;
  logic [1:0]       w_pop;
  logic             w_play;
  logic             w_under;
  logic [15:0]      w_lsamp;
  logic [15:0]      w_rsamp;
  logic [OUT_W-1:0] w_left_off;
  logic [OUT_W-1:0] w_right_off;
  bytesel_e         w_bs_nxt;

  // Rate generator keeps running while playback is disabled.
  always_ff @(posedge clk32) begin
    if (!resb) begin
      r_base_cnt <= '0;
      r_base_en  <= 1'b0;
      r_aclk_cnt <= '0;
    end else begin
      r_base_en <= (r_base_cnt == CNT_TOP);
      if (r_base_cnt == CNT_TOP) begin
        r_base_cnt <= '0;
      end else begin
        r_base_cnt <= r_base_cnt + 1'b1;
      end
      if (r_base_en) begin
        r_aclk_cnt <= r_aclk_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    case (sndmode[1:0])
      RATE_50K:  w_rate_ok = 1'b1;
      RATE_25K:  w_rate_ok = ~r_aclk_cnt[0];
      RATE_12K5: w_rate_ok = (r_aclk_cnt[1:0] == 2'b00);
      default:   w_rate_ok = (r_aclk_cnt == 3'b000);
    endcase
  end

  assign w_tick     = enable & r_base_en & w_rate_ok;
  assign w_push_req = enable & ~r_sload_d & SLOAD_N;
  // Full is judged before any pop in the same cycle.
  assign w_full     = (fifo_level == LVL_FULL);
  assign w_push     = w_push_req & ~w_full;
  assign w_16b      = sndmode[SM_16B];
  assign w_mono     = ~sndmode[SM_16B] & sndmode[SM_MONO];
  assign w_mode_chg = (sndmode != r_mode_d);
  assign w_mono_b   = (r_bytesel == BS_LO) ?
                      w_rd0[7:0] : w_rd0[15:8];

  sound_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .i_clk   (clk32),
    .i_rst_n (resb),
    .i_flush (~enable),
    .i_push  (w_push),
    .i_wdata (MDIN),
    .i_pop   (w_pop),
    .o_rd0   (w_rd0),
    .o_rd1   (w_rd1),
    .o_level (fifo_level)
  );

  always_comb begin
    w_pop    = 2'd0;
    w_play   = 1'b0;
    w_under  = 1'b0;
    w_lsamp  = 16'h0000;
    w_rsamp  = 16'h0000;
    w_bs_nxt = r_bytesel;
    if (w_tick) begin
      unique case (1'b1)
        w_16b: begin
          if (fifo_level >= LVL_TWO) begin
            w_play  = 1'b1;
            w_pop   = 2'd2;
            w_lsamp = w_rd0;
            w_rsamp = w_rd1;
          end else begin
            w_under = 1'b1;
          end
        end
        w_mono: begin
          if (fifo_level != '0) begin
            w_play   = 1'b1;
            w_lsamp  = {w_mono_b, 8'h00};
            w_rsamp  = {w_mono_b, 8'h00};
            w_pop    = (r_bytesel == BS_LO) ?
                       2'd1 : 2'd0;
            w_bs_nxt = (r_bytesel == BS_LO) ?
                       BS_HI : BS_LO;
          end else begin
            w_under = 1'b1;
          end
        end
        default: begin
          if (fifo_level != '0) begin
            w_play  = 1'b1;
            w_pop   = 2'd1;
            w_lsamp = {w_rd0[15:8], 8'h00};
            w_rsamp = {w_rd0[7:0], 8'h00};
          end else begin
            w_under = 1'b1;
          end
        end
      endcase
    end
    // A mode switch restarts mono at the high byte.
    if (w_mode_chg) begin
      w_bs_nxt = BS_HI;
    end
  end

  assign w_left_off  = OUT_W'(to_offset(w_lsamp, OUT_W));
  assign w_right_off = OUT_W'(to_offset(w_rsamp, OUT_W));

  always_ff @(posedge clk32) begin
    if (!resb) begin
      r_sload_d <= 1'b1;
      r_mode_d  <= '0;
      r_bytesel <= BS_HI;
      r_left    <= MID;
      r_right   <= MID;
      r_under   <= 1'b0;
      r_over    <= 1'b0;
      r_sreq    <= 1'b0;
    end else begin
      r_sload_d <= SLOAD_N;
      r_mode_d  <= sndmode;
      r_sreq    <= enable & (fifo_level <= LVL_REQ);
      r_under   <= w_under;
      r_over    <= w_push_req & w_full;
      if (!enable) begin
        r_bytesel <= BS_HI;
        r_left    <= MID;
        r_right   <= MID;
      end else begin
        r_bytesel <= w_bs_nxt;
        if (w_play) begin
          r_left  <= w_left_off;
          r_right <= w_right_off;
        end
      end
    end
  end

  assign SREQ        = r_sreq;
  assign audio_left  = r_left;
  assign audio_right = r_right;
  assign underrun    = r_under;
  assign overflow    = r_over;

endmodule
